// File: rtl/accum_xcel_param_if.sv
// Memory request/response channel between the accumulator accelerator and its memory port.
// Requests use valid/ready; responses return in request order and are always accepted.
interface accum_xcel_param_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              memreq_val;
  logic              memreq_rdy;
  logic [ADDR_W-1:0] memreq_addr;
  logic              memresp_val;
  logic [DATA_W-1:0] memresp_data;

  modport master (
    output memreq_val,
    output memreq_addr,
    input  memreq_rdy,
    input  memresp_val,
    input  memresp_data
  );

  modport slave (
    input  memreq_val,
    input  memreq_addr,
    output memreq_rdy,
    output memresp_val,
    output memresp_data
  );
endinterface

// File: rtl/accum_xcel_param.sv
// Streaming reduction accelerator: fetches size words from base_addr (stride 4) and
// folds them with wrapping sum, saturating sum, unsigned max or unsigned min.
module accum_xcel_param #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ACC_W        = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned SIZE_W       = 14,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE_W-1:0] size,
  output logic              busy,
  output logic              result_val,
  output logic [ACC_W-1:0]  result,
  accum_xcel_param_if.master mem
);

  localparam int unsigned INF_W = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] issued_q, issued_d;
  logic [SIZE_W-1:0] recvd_q, recvd_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              result_val_q, result_val_d;
  logic              req_val_q, req_val_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic              fire_c;
  logic              resp_ok_c;
  logic [ACC_W-1:0]  data_ext_c;
  logic [ACC_W:0]    sum_c;
  logic [ACC_W-1:0]  combined_c;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    base_d       = base_q;
    size_d       = size_q;
    issued_d     = issued_q;
    recvd_d      = recvd_q;
    inflight_d   = inflight_q;
    acc_d        = acc_q;

    fire_c     = req_val_q & mem.memreq_rdy;
    resp_ok_c  = mem.memresp_val && (state_q == ST_RUN) && (inflight_q != '0);
    data_ext_c = ACC_W'(mem.memresp_data);
    sum_c      = {1'b0, acc_q} + {1'b0, data_ext_c};

    unique case (mode_q)
      2'd0:    combined_c = sum_c[ACC_W-1:0];
      2'd1:    combined_c = sum_c[ACC_W] ? '1 : sum_c[ACC_W-1:0];
      2'd2:    combined_c = (data_ext_c > acc_q) ? data_ext_c : acc_q;
      default: combined_c = (data_ext_c < acc_q) ? data_ext_c : acc_q;
    endcase

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d    = ST_RUN;
          mode_d     = mode;
          base_d     = base_addr;
          size_d     = size;
          issued_d   = '0;
          recvd_d    = '0;
          inflight_d = '0;
          acc_d      = (mode == 2'd3) ? '1 : '0;
        end
      end
      ST_RUN: begin
        if (fire_c) begin
          issued_d = issued_q + SIZE_W'(1);
        end
        if (resp_ok_c) begin
          recvd_d = recvd_q + SIZE_W'(1);
          acc_d   = combined_c;
        end
        // A simultaneous issue and retire leaves the outstanding count alone
        if (fire_c && !resp_ok_c) begin
          inflight_d = inflight_q + INF_W'(1);
        end else if (!fire_c && resp_ok_c) begin
          inflight_d = inflight_q - INF_W'(1);
        end
        if (recvd_d == size_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d == ST_RUN);
    result_val_d = (state_d == ST_DONE);
    req_val_d    = (state_d == ST_RUN) && (issued_d < size_d) &&
                   (inflight_d < INF_W'(MAX_INFLIGHT));
    // Address only advances on a fire, so it holds while the memory stalls
    req_addr_d   = base_d + ADDR_W'({issued_d, 2'b00});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      base_q       <= '0;
      size_q       <= '0;
      issued_q     <= '0;
      recvd_q      <= '0;
      inflight_q   <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      result_val_q <= 1'b0;
      req_val_q    <= 1'b0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      size_q       <= size_d;
      issued_q     <= issued_d;
      recvd_q      <= recvd_d;
      inflight_q   <= inflight_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      result_val_q <= result_val_d;
      req_val_q    <= req_val_d;
      req_addr_q   <= req_addr_d;
    end
  end

  assign busy            = busy_q;
  assign result_val      = result_val_q;
  assign result          = acc_q;
  assign mem.memreq_val  = req_val_q;
  assign mem.memreq_addr = req_addr_q;

endmodule

// File: tb/tb_accum_xcel_param.sv
// Self-checking bench for accum_xcel_param: in-order variable-latency memory model,
// reference reduction computed from the element list, directed plus randomized runs.
module tb_accum_xcel_param;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ACC_W        = 32;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned SIZE_W       = 14;
  localparam int unsigned MAX_INFLIGHT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [SIZE_W-1:0] size;
  logic              busy;
  logic              result_val;
  logic [ACC_W-1:0]  result;

  accum_xcel_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  accum_xcel_param #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W),
    .SIZE_W(SIZE_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .base_addr(base_addr), .size(size),
    .busy(busy), .result_val(result_val), .result(result), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory model state
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } resp_t;

  logic [DATA_W-1:0] mem_words [0:(1 << (ADDR_W - 2)) - 1];
  resp_t             pend_q[$];
  logic [ADDR_W-1:0] fired_q[$];
  logic [DATA_W-1:0] stim_q[$];
  bit                rdy_rand = 1'b0;
  int                lat_max = 1;
  int                cyc = 0;
  int                n_fired = 0;
  int                n_resp = 0;

  // Memory: updates at negedge so values are stable for the next rising edge
  initial begin : mem_model
    logic              prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    resp_t             r;
    prev_stall = 1'b0;
    prev_addr  = '0;
    mem_if.memreq_rdy   = 1'b0;
    mem_if.memresp_val  = 1'b0;
    mem_if.memresp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (prev_stall && rst) begin
        check_eq("req_val_hold", 64'(mem_if.memreq_val), 64'd1);
        check_eq("req_addr_hold", 64'(mem_if.memreq_addr), 64'(prev_addr));
      end
      mem_if.memresp_val  = 1'b0;
      mem_if.memresp_data = DATA_W'($urandom);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        mem_if.memresp_val  = 1'b1;
        mem_if.memresp_data = r.data;
        n_resp++;
      end
      mem_if.memreq_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_if.memreq_val && mem_if.memreq_rdy) begin
        fired_q.push_back(mem_if.memreq_addr);
        r.data = mem_words[mem_if.memreq_addr[ADDR_W-1:2]];
        r.due  = cyc + ((lat_max > 1) ? int'($urandom_range(1, lat_max)) : 1);
        pend_q.push_back(r);
        n_fired++;
        check_eq("inflight_max", 64'((n_fired - n_resp) <= int'(MAX_INFLIGHT)), 64'd1);
      end
      prev_stall = mem_if.memreq_val && !mem_if.memreq_rdy;
      prev_addr  = mem_if.memreq_addr;
    end
  end

  // Reference reduction over stim_q[0..n-1]
  function automatic logic [ACC_W-1:0] ref_reduce(input logic [1:0] m, input int n);
    longint unsigned mask, acc, d;
    mask = (64'd1 << ACC_W) - 64'd1;
    acc  = (m == 2'd3) ? mask : 64'd0;
    for (int i = 0; i < n; i++) begin
      d = 64'(stim_q[i]);
      case (m)
        2'd0:    acc = (acc + d) & mask;
        2'd1:    acc = ((acc + d) > mask) ? mask : acc + d;
        2'd2:    acc = (d > acc) ? d : acc;
        default: acc = (d < acc) ? d : acc;
      endcase
    end
    return ACC_W'(acc);
  endfunction

  task automatic run(input string tag, input logic [1:0] m, input logic [ADDR_W-1:0] b,
                     input int n, input bit rr, input int lm, input int exp_lat, input bit mid_go);
    logic [ADDR_W-1:0] a;
    logic [ACC_W-1:0]  exp_res;
    int                lat;
    for (int i = 0; i < n; i++) begin
      a = b + ADDR_W'(4 * i);
      mem_words[a[ADDR_W-1:2]] = stim_q[i];
    end
    exp_res  = ref_reduce(m, n);
    rdy_rand = rr;
    lat_max  = lm;
    fired_q.delete();
    @(negedge clk);
    go = 1'b1; mode = m; base_addr = b; size = SIZE_W'(n);
    @(posedge clk);
    #1;
    go = 1'b0;
    mode = 2'($urandom); base_addr = ADDR_W'($urandom); size = SIZE_W'($urandom);
    check_eq({tag, "_busy_start"}, 64'(busy), 64'd1);
    check_eq({tag, "_rv_drop"}, 64'(result_val), 64'd0);
    lat = 1;
    while (!result_val && lat < 400) begin
      go = (mid_go && lat == 3);
      @(posedge clk);
      #1;
      lat++;
    end
    go = 1'b0;
    check_eq({tag, "_done"}, 64'(result_val), 64'd1);
    if (exp_lat > 0) check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_eq({tag, "_nreq"}, 64'(fired_q.size()), 64'(n));
    for (int i = 0; i < n && i < fired_q.size(); i++)
      check_eq({tag, "_addr"}, 64'(fired_q[i]), 64'(ADDR_W'(b + ADDR_W'(4 * i))));
    repeat (3) @(posedge clk);
    #1;
    check_eq({tag, "_rv_hold"}, 64'(result_val), 64'd1);
    check_eq({tag, "_res_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin : main
    int wait_cyc;
    rst = 1'b0; go = 1'b0; mode = '0; base_addr = '0; size = '0;
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rv", 64'(result_val), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_req_val", 64'(mem_if.memreq_val), 64'd0);
    check_eq("rst_req_addr", 64'(mem_if.memreq_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run("sum4", 2'd0, 16'h0100, 4, 1'b0, 1, 6, 1'b0);
    stim_q = '{32'hFFFF_FFF0, 32'h20};
    run("sat", 2'd1, 16'h0200, 2, 1'b0, 1, 4, 1'b0);
    run("wrap", 2'd0, 16'h0200, 2, 1'b0, 1, 4, 1'b0);
    stim_q = '{32'd7, 32'h80, 32'd3};
    run("max", 2'd2, 16'h0300, 3, 1'b1, 5, 0, 1'b0);
    run("min", 2'd3, 16'h0300, 3, 1'b1, 5, 0, 1'b0);
    stim_q.delete();
    run("size0", 2'd3, 16'h0400, 0, 1'b0, 1, 2, 1'b0);
    stim_q = '{32'hA, 32'hB};
    run("addrwrap", 2'd0, 16'hFFFC, 2, 1'b0, 1, 4, 1'b0);

    stim_q.delete();
    for (int i = 0; i < 10; i++) stim_q.push_back(DATA_W'($urandom_range(0, 1000)));
    run("midgo", 2'd0, 16'h0500, 10, 1'b1, 4, 0, 1'b1);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 20);
      stim_q.delete();
      for (int i = 0; i < n; i++)
        stim_q.push_back($urandom_range(0, 1) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 255)));
      run("rand", 2'($urandom_range(0, 3)), ADDR_W'($urandom), n, 1'b1, 5, 0, 1'b0);
    end

    // Reset with two requests outstanding
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(DATA_W'(i + 100));
    for (int i = 0; i < 8; i++) mem_words[(16'h0600 >> 2) + i] = stim_q[i];
    rdy_rand = 1'b0;
    lat_max  = 5;
    @(negedge clk);
    go = 1'b1; mode = 2'd0; base_addr = 16'h0600; size = SIZE_W'(8);
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_cyc = 0;
    while ((n_fired - n_resp) != 2 && wait_cyc < 50) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    check_eq("rst_mid_two_out", 64'(n_fired - n_resp), 64'd2);
    rst = 1'b0;
    #1;
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_rv", 64'(result_val), 64'd0);
    check_eq("rstmid_result", 64'(result), 64'd0);
    check_eq("rstmid_req_val", 64'(mem_if.memreq_val), 64'd0);
    check_eq("rstmid_req_addr", 64'(mem_if.memreq_addr), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_cyc = 0;
    while (pend_q.size() > 0 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    repeat (2) @(negedge clk);
    check_eq("late_resp_result", 64'(result), 64'd0);
    check_eq("late_resp_rv", 64'(result_val), 64'd0);
    check_eq("late_resp_busy", 64'(busy), 64'd0);
    stim_q = '{32'd5};
    run("after_rst", 2'd0, 16'h0700, 1, 1'b0, 1, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_xcel_param.md
# accum_xcel_param

Parametrised successor to the single-mode accumulator accelerator. On `go`, it streams `size` words from memory starting at a programmable base address and reduces them with a selectable operation: wrapping sum, saturating sum, max or min. It sits between the processor's accelerator command port and a memory port that supports valid/ready requests, variable response latency and multiple requests in flight. Responses return in order.

## Interface
Parameters:
- `DATA_W`, 32: memory data width.
- `ACC_W`, 32: accumulator/result width. Must be ≥ `DATA_W`.
- `ADDR_W`, 16: byte-address width.
- `SIZE_W`, 14: element-count width.
- `MAX_INFLIGHT`, 2: maximum outstanding memory requests. Must be ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `go`  in  1  start pulse; accepted only in IDLE or DONE.
- `mode`  in  2  0 = wrapping sum, 1 = saturating unsigned sum, 2 = unsigned max, 3 = unsigned min.
- `base_addr`  in  ADDR_W  byte address of element 0.
- `size`  in  SIZE_W  number of elements.
- `busy`  out  1  high in RUN.
- `result_val`  out  1  high in DONE.
- `result`  out  ACC_W  reduction result; valid while `result_val` is high.
- `memreq_val`  out  1  request valid.
- `memreq_rdy`  in  1  memory accepts a request.
- `memreq_addr`  out  ADDR_W  request byte address.
- `memresp_val`  in  1  response valid. Responses arrive in request order.
- `memresp_data`  in  DATA_W  response data.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN when `go` is high.
  - DONE → RUN when `go` is high.
  - RUN → DONE when the last response is accepted, or immediately when `size` = 0.
- `go` in RUN is ignored.
- On `go` acceptance:
  - latch `mode`, `base_addr` and `size`;
  - clear the issue count, receive count and inflight count;
  - load the accumulator with the identity: 0 for modes 0/1/2, all-ones for mode 3.
- `size` = 0: go RUN→DONE after one RUN cycle. `memreq_val` stays 0 and `result` is the identity.
- Request i address = `base_addr` + 4·i, truncated modulo 2^ADDR_W. Address wrap-around is legal.
- `memreq_val` = RUN && issued < size && inflight < `MAX_INFLIGHT`. It depends only on state, never combinationally on `memreq_rdy`.
- A request fires when `memreq_val` && `memreq_rdy`; issued increments.
- A response is accepted when `memresp_val` && RUN && inflight > 0; received increments.
  - A response with inflight = 0, or outside RUN, is ignored.
- A fire and a response accepted in the same cycle leave inflight unchanged.
- Data is zero-extended to ACC_W before combining:
  - mode 0: acc + d, modulo 2^ACC_W;
  - mode 1: acc + d, clamped to 2^ACC_W−1;
  - mode 2: max(acc, d);
  - mode 3: min(acc, d).
- `result` holds the accumulator and is stable throughout DONE.
- Reset values: state IDLE; `busy` 0, `result_val` 0, `result` 0, `memreq_val` 0, `memreq_addr` 0; all counters 0.
- Reset mid-RUN returns to IDLE immediately. Responses arriving after reset are ignored because inflight = 0.

## Timing
- `go` sampled high at edge E → `busy` = 1 and the first request is presented in the cycle after E.
- Zero-wait memory (rdy = 1, response one cycle after fire) with `MAX_INFLIGHT` ≥ 2:
  - one request fires per cycle;
  - `result_val` rises N+2 cycles after E for `size` = N.
- `MAX_INFLIGHT` = 1 with the same memory: requests fire every other cycle and `result_val` rises 2N+1 cycles after E.
- `result_val` rises in the cycle after the final response is accepted.
- `result_val` stays high until a new `go` is accepted, then drops in the next cycle.
- `memreq_addr` is held stable while `memreq_val` = 1 and `memreq_rdy` = 0.

## Test plan
- Mode 0, base 0x0100, size 4, data {1, 2, 3, 4}, zero-wait memory → addresses 0x0100/0x0104/0x0108/0x010C; `result` = 10; `result_val` at E+6.
- Mode 1, ACC_W = DATA_W = 32, data {0xFFFF_FFF0, 0x20} → `result` = 0xFFFF_FFFF. Mode 0 with the same data → 0x10.
- Modes 2 and 3, data {7, 0x80, 3}, with `memreq_rdy` toggled randomly and response latency 1–5 cycles → max = 0x80, min = 3; `memreq_addr` stable under stall; inflight never exceeds `MAX_INFLIGHT`.
- `size` = 0 in mode 3 → no requests issued; `result` = 0xFFFF_FFFF; `result_val` at E+2. Also: base 0xFFFC, size 2 → addresses 0xFFFC, 0x0000.
- `go` pulsed mid-RUN is ignored. `go` in DONE restarts: `result_val` drops next cycle and the new result reflects only the new run.
- `rst` asserted mid-RUN with 2 requests outstanding → outputs at reset values asynchronously. Late responses are ignored, and a following `go` (size 1, data 5) gives `result` = 5.
